// File: rtl/rob_if.sv
// Reorder-buffer bus bundle: dispatch allocation, completion broadcast,
// retirement and flush signals. The master side is dispatch/execute, the
// slave side is the reorder buffer itself.
interface rob_if #(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 3
);
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [REG_W-1:0]         alloc_rd;
  logic                     alloc_is_branch;
  logic [TAG_W-1:0]         alloc_tag;

  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_value;
  logic [NUM_CDB-1:0]       cdb_exc;

  logic                     commit_valid;
  logic                     commit_wb;
  logic [REG_W-1:0]         commit_rd;
  logic [XLEN-1:0]          commit_data;
  logic [TAG_W-1:0]         commit_tag;

  logic                     flush;
  logic [XLEN-1:0]          flush_pc;

  logic [TAG_W:0]           count;
  logic                     empty;
  logic                     full;

  modport master (
    output alloc_valid, alloc_rd, alloc_is_branch,
    output cdb_valid, cdb_tag, cdb_value, cdb_exc,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_wb, commit_rd, commit_data, commit_tag,
    input  flush, flush_pc, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_is_branch,
    input  cdb_valid, cdb_tag, cdb_value, cdb_exc,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_wb, commit_rd, commit_data, commit_tag,
    output flush, flush_pc, count, empty, full
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: allocates tags in program order, absorbs
// results from NUM_CDB completion buses and retires strictly in order, one
// entry per cycle. An excepting/mispredicted head flushes everything and
// publishes the redirect PC carried in that entry's value field.
module rob_param #(
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int NUM_CDB = 2
) (
  input logic  clk,
  input logic  rst_n,
  rob_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_exc;
  logic [DEPTH-1:0] ent_branch;
  logic [REG_W-1:0] ent_rd    [DEPTH];
  logic [XLEN-1:0]  ent_value [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   occupied;

  logic             full_int;
  logic             alloc_fire;
  logic             commit_fire;
  logic             flush_fire;

  logic [TAG_W-1:0] cdb_tag_arr [NUM_CDB];
  logic [XLEN-1:0]  cdb_val_arr [NUM_CDB];

  logic             commit_valid_q;
  logic             commit_wb_q;
  logic [REG_W-1:0] commit_rd_q;
  logic [XLEN-1:0]  commit_data_q;
  logic [TAG_W-1:0] commit_tag_q;
  logic             flush_q;
  logic [XLEN-1:0]  flush_pc_q;

  // Full/empty come from the occupancy counter; pointers alone are ambiguous.
  assign full_int        = (occupied == (TAG_W+1)'(DEPTH));
  assign alloc_fire      = bus.alloc_valid && !full_int;
  assign commit_fire     = ent_valid[head] && ent_done[head] && !ent_exc[head];
  assign flush_fire      = ent_valid[head] && ent_done[head] &&  ent_exc[head];

  assign bus.alloc_ready  = !full_int;
  assign bus.alloc_tag    = tail;
  assign bus.count        = occupied;
  assign bus.empty        = (occupied == '0);
  assign bus.full         = full_int;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_wb    = commit_wb_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_data  = commit_data_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;

  // Unpack the flat completion buses into per-port tag/value arrays.
  always_comb begin
    for (int i = 0; i < NUM_CDB; i++) begin
      cdb_tag_arr[i] = bus.cdb_tag[i*TAG_W +: TAG_W];
      cdb_val_arr[i] = bus.cdb_value[i*XLEN +: XLEN];
    end
  end

  // Entry table, pointers and registered commit/flush outputs; a flush
  // overrides any allocation or completion arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid      <= '0;
      ent_done       <= '0;
      ent_exc        <= '0;
      ent_branch     <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_rd[e]    <= '0;
        ent_value[e] <= '0;
      end
      head           <= '0;
      tail           <= '0;
      occupied       <= '0;
      commit_valid_q <= 1'b0;
      commit_wb_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (flush_fire) begin
      ent_valid      <= '0;
      ent_done       <= '0;
      ent_exc        <= '0;
      head           <= '0;
      tail           <= '0;
      occupied       <= '0;
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b1;
      flush_pc_q     <= ent_value[head];
    end else begin
      flush_q        <= 1'b0;
      commit_valid_q <= 1'b0;

      if (alloc_fire) begin
        ent_valid[tail]  <= 1'b1;
        ent_done[tail]   <= 1'b0;
        ent_exc[tail]    <= 1'b0;
        ent_branch[tail] <= bus.alloc_is_branch;
        ent_rd[tail]     <= bus.alloc_rd;
        tail             <= tail + TAG_W'(1);
      end

      for (int i = 0; i < NUM_CDB; i++) begin
        if (bus.cdb_valid[i] && ent_valid[cdb_tag_arr[i]]) begin
          ent_done[cdb_tag_arr[i]]  <= 1'b1;
          ent_exc[cdb_tag_arr[i]]   <= bus.cdb_exc[i];
          ent_value[cdb_tag_arr[i]] <= cdb_val_arr[i];
        end
      end

      if (commit_fire) begin
        commit_valid_q  <= 1'b1;
        commit_wb_q     <= !ent_branch[head];
        commit_rd_q     <= ent_rd[head];
        commit_data_q   <= ent_value[head];
        commit_tag_q    <= head;
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + TAG_W'(1);
      end

      occupied <= occupied + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
    end
  end
endmodule
